decode_arbiter: RTL and testbench

DECODE_ARBITER -- requirements
Module: decode_arbiter

---
 rtl/decode_arbiter.sv | 101 ++++++++++
 tb/tb_decode_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_arbiter.sv
// rtl/decode_arbiter.sv - two-requester round-robin front end for a shared fixed-latency decoder
// One word in flight: grant in IDLE, wait DEC_LAT cycles, hold result in RESP until consumed.
module decode_arbiter #(
  parameter int DEC_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic [31:0] dec_word,
  input  logic [5:0]  dec_comp,
  input  logic [2:0]  dec_inst,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [5:0]  rsp_comp,
  output logic [2:0]  rsp_inst,
  output logic        busy,
  output logic [15:0] issue_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        ptr;
  logic [3:0]  wait_cnt;
  logic        grant_any;
  logic        grant_id;
  logic        accept;
  logic        capture;

  // A lone valid requester wins outright; the pointer only breaks ties.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = req1_valid & (~req0_valid | ptr);
    accept    = rst_n & (state == S_IDLE) & grant_any;
    capture   = (state == S_WAIT) & (wait_cnt == 4'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_WAIT;
      S_WAIT: if (capture) state_nxt = S_RESP;
      S_RESP: if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = accept & ~grant_id;
    req1_ready = accept & grant_id;
    rsp_valid  = (state == S_RESP);
    busy       = (state != S_IDLE);
  end

  // dec_word is written only on accept so the decoder input holds between words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_word  <= 32'd0;
      rsp_id    <= 1'b0;
      ptr       <= 1'b0;
      wait_cnt  <= 4'd0;
      issue_cnt <= 16'd0;
      rsp_comp  <= 6'd0;
      rsp_inst  <= 3'd0;
    end else begin
      if (accept) begin
        dec_word  <= grant_id ? req1_data : req0_data;
        rsp_id    <= grant_id;
        ptr       <= ~grant_id;
        wait_cnt  <= 4'(DEC_LAT);
        issue_cnt <= issue_cnt + 16'd1;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (capture) begin
        rsp_comp <= dec_comp;
        rsp_inst <= dec_inst;
      end
    end
  end

endmodule

// File: tb/tb_decode_arbiter.sv
// tb/tb_decode_arbiter.sv - self-checking bench for decode_arbiter (DEC_LAT=1 and DEC_LAT=4 instances)
module tb_decode_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_v0, a_v1, a_r0, a_r1, a_rv, a_rr, a_id, a_busy;
  logic [31:0] a_d0, a_d1, a_word;
  logic [5:0]  a_comp, a_rc;
  logic [2:0]  a_inst, a_ri;
  logic [15:0] a_cnt;
  logic [8:0]  a_noise;

  logic        b_v0, b_v1, b_r0, b_r1, b_rv, b_rr, b_id, b_busy;
  logic [31:0] b_d0, b_d1, b_word;
  logic [5:0]  b_comp, b_rc;
  logic [2:0]  b_inst, b_ri;
  logic [15:0] b_cnt;

  int errors = 0;
  int checks = 0;

  // Decoder stubs; a_noise perturbs the decoder outside the capture edge.
  assign a_comp = a_word[5:0] ^ a_noise[5:0];
  assign a_inst = a_word[2:0] ^ a_noise[8:6];
  assign b_comp = b_word[5:0];
  assign b_inst = b_word[8:6];

  decode_arbiter #(.DEC_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(a_v0), .req0_data(a_d0), .req0_ready(a_r0),
    .req1_valid(a_v1), .req1_data(a_d1), .req1_ready(a_r1),
    .dec_word(a_word), .dec_comp(a_comp), .dec_inst(a_inst),
    .rsp_valid(a_rv), .rsp_ready(a_rr), .rsp_id(a_id),
    .rsp_comp(a_rc), .rsp_inst(a_ri), .busy(a_busy), .issue_cnt(a_cnt)
  );

  decode_arbiter #(.DEC_LAT(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(b_v0), .req0_data(b_d0), .req0_ready(b_r0),
    .req1_valid(b_v1), .req1_data(b_d1), .req1_ready(b_r1),
    .dec_word(b_word), .dec_comp(b_comp), .dec_inst(b_inst),
    .rsp_valid(b_rv), .rsp_ready(b_rr), .rsp_id(b_id),
    .rsp_comp(b_rc), .rsp_inst(b_ri), .busy(b_busy), .issue_cnt(b_cnt)
  );

  task automatic clear_inputs();
    a_v0 = 0; a_v1 = 0; a_d0 = 0; a_d1 = 0; a_rr = 0; a_noise = 0;
    b_v0 = 0; b_v1 = 0; b_d0 = 0; b_d1 = 0; b_rr = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    a_v0 = 1; a_v1 = 1; a_d0 = 32'h11; a_d1 = 32'h22;
    @(negedge clk); #1;
    checks++;
    if ({a_r0, a_r1, b_r0, b_r1} !== 4'b0) begin
      errors++; $display("FAIL reset_ready got %b exp 0000", {a_r0, a_r1, b_r0, b_r1});
    end
    checks++;
    if ({a_word, a_rv, a_id, a_rc, a_ri, a_busy, a_cnt} !== 60'd0) begin
      errors++; $display("FAIL reset_outputs got word=%h rv=%b id=%b comp=%h inst=%h busy=%b cnt=%h exp all 0",
                         a_word, a_rv, a_id, a_rc, a_ri, a_busy, a_cnt);
    end
    @(negedge clk);
    rst_n = 1;
    #1;
    checks++;
    if ({a_r0, a_r1} !== 2'b10) begin
      errors++; $display("FAIL first_accept_after_reset got %b exp 10", {a_r0, a_r1});
    end
    @(posedge clk);
    @(negedge clk);
    a_v0 = 0; a_v1 = 0; a_rr = 1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    int n;
    do_reset();
    a_v0 = 1; a_d0 = 32'h0000_0005; a_rr = 1;
    #1;
    checks++;
    if ({a_r0, a_r1} !== 2'b10) begin
      errors++; $display("FAIL single_grant got %b exp 10", {a_r0, a_r1});
    end
    @(negedge clk);
    a_v0 = 0;
    #1;
    checks++;
    if ({a_rv, a_busy, a_cnt, a_word} !== {1'b0, 1'b1, 16'd1, 32'h5}) begin
      errors++; $display("FAIL single_wait got rv=%b busy=%b cnt=%0d word=%h exp 0 1 1 5", a_rv, a_busy, a_cnt, a_word);
    end
    n = 1;
    @(negedge clk); #1;
    checks++;
    if ({a_rv, a_id, a_rc, a_ri} !== {1'b1, 1'b0, 6'h05, 3'h5}) begin
      errors++; $display("FAIL single_resp got rv=%b id=%b comp=%h inst=%h exp 1 0 05 5", a_rv, a_id, a_rc, a_ri);
    end
    @(negedge clk); #1;
    checks++;
    if ({a_rv, a_busy} !== 2'b00) begin
      errors++; $display("FAIL single_idle got rv=%b busy=%b exp 0 0 (n=%0d)", a_rv, a_busy, n);
    end
  endtask

  task automatic test_round_robin();
    int gid[$];
    int gcyc[$];
    int rid[$];
    do_reset();
    a_v0 = 1; a_v1 = 1; a_d0 = 32'hA0; a_d1 = 32'hB1; a_rr = 1;
    for (int c = 0; c < 60 && rid.size() < 4; c++) begin
      #1;
      checks++;
      if (a_r0 && a_r1) begin
        errors++; $display("FAIL rr_both_ready got 11 exp not both at cycle %0d", c);
      end
      if (a_r0) begin gid.push_back(0); gcyc.push_back(c); end
      if (a_r1) begin gid.push_back(1); gcyc.push_back(c); end
      if (a_rv) rid.push_back(int'(a_id));
      @(negedge clk);
    end
    a_v0 = 0; a_v1 = 0;
    checks++;
    if (gid.size() < 4 || rid.size() < 4) begin
      errors++; $display("FAIL rr_count got grants=%0d rsps=%0d exp >=4", gid.size(), rid.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (gid[i] != i % 2 || rid[i] != i % 2) begin
          errors++; $display("FAIL rr_order[%0d] got grant=%0d rsp=%0d exp %0d", i, gid[i], rid[i], i % 2);
        end
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (gcyc[i] - gcyc[i-1] != 3) begin
          errors++; $display("FAIL rr_interval[%0d] got %0d exp 3", i, gcyc[i] - gcyc[i-1]);
        end
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    b_v0 = 1; b_d0 = 32'h0000_01C5; b_rr = 0;
    #1;
    checks++;
    if (b_r0 !== 1'b1) begin
      errors++; $display("FAIL bp_grant got %b exp 1", b_r0);
    end
    @(posedge clk);
    @(negedge clk);
    b_v0 = 0;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); n++;
      @(negedge clk); #1;
      if (b_rv) break;
    end
    checks++;
    if (n != 4 || b_rv !== 1'b1) begin
      errors++; $display("FAIL bp_latency got %0d rv=%b exp 4 1", n, b_rv);
    end
    b_v0 = 1; b_v1 = 1; b_d0 = 32'hFFFF_FFFF; b_d1 = 32'hFFFF_FFFF;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if ({b_rv, b_id, b_rc, b_ri, b_r0, b_r1, b_busy, b_word} !== {1'b1, 1'b0, 6'h05, 3'h7, 2'b00, 1'b1, 32'h1C5}) begin
        errors++; $display("FAIL bp_hold[%0d] got rv=%b id=%b comp=%h inst=%h rdy=%b%b busy=%b word=%h exp 1 0 05 7 00 1 1c5",
                           c, b_rv, b_id, b_rc, b_ri, b_r0, b_r1, b_busy, b_word);
      end
      @(negedge clk);
    end
    b_v0 = 0; b_v1 = 0; b_rr = 1;
    @(negedge clk); #1;
    checks++;
    if ({b_rv, b_busy} !== 2'b00) begin
      errors++; $display("FAIL bp_release got rv=%b busy=%b exp 0 0", b_rv, b_busy);
    end
    b_rr = 0;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    b_v0 = 1; b_d0 = 32'hDEAD_BEEF; b_rr = 1;
    @(negedge clk);
    b_v0 = 0;
    @(negedge clk);
    b_v1 = 1; b_d1 = 32'h1234;
    #1 rst_n = 0;
    #1;
    checks++;
    if ({b_word, b_rv, b_id, b_rc, b_ri, b_busy, b_cnt, b_r0, b_r1} !== 62'd0) begin
      errors++; $display("FAIL rst_mid_wait got word=%h rv=%b id=%b comp=%h inst=%h busy=%b cnt=%h rdy=%b%b exp all 0",
                         b_word, b_rv, b_id, b_rc, b_ri, b_busy, b_cnt, b_r0, b_r1);
    end
    #1 rst_n = 1;
    b_v1 = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      checks++;
      if (b_rv !== 1'b0 || b_busy !== 1'b0) begin
        errors++; $display("FAIL rst_no_resp[%0d] got rv=%b busy=%b exp 0 0", c, b_rv, b_busy);
      end
    end
    b_rr = 0;
  endtask

  task automatic test_sweep();
    bit got;
    do_reset();
    a_rr = 1;
    for (int w = 0; w <= 10; w++) begin
      logic [31:0] wd;
      wd = 32'(w);
      a_v0 = 1; a_d0 = wd;
      #1;
      got = a_r0;
      @(negedge clk);
      a_v0 = 0;
      checks++;
      if (!got) begin
        errors++; $display("FAIL sweep_accept[%0d] got 0 exp 1", w);
      end
      got = 0;
      for (int c = 0; c < 6 && !got; c++) begin
        #1;
        if (a_rv) got = 1;
        else @(negedge clk);
      end
      checks++;
      if (!got || a_rc !== wd[5:0] || a_ri !== wd[2:0] || a_id !== 1'b0) begin
        errors++; $display("FAIL sweep_resp[%0d] got rv=%b comp=%h inst=%h id=%b exp 1 %h %h 0", w, got, a_rc, a_ri, a_id, wd[5:0], wd[2:0]);
      end
      @(negedge clk);
    end
    checks++;
    if (a_cnt !== 16'd11) begin
      errors++; $display("FAIL sweep_count got %0d exp 11", a_cnt);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk);
    force dut_a.issue_cnt = 16'hFFFF;
    #1;
    release dut_a.issue_cnt;
    #1;
    checks++;
    if (a_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_preset got %h exp ffff", a_cnt);
    end
    a_v1 = 1; a_d1 = 32'h3C; a_rr = 1;
    @(negedge clk);
    a_v1 = 0;
    #1;
    checks++;
    if (a_cnt !== 16'h0000) begin
      errors++; $display("FAIL wrap_count got %h exp 0000", a_cnt);
    end
    repeat (3) @(negedge clk);
  endtask

  // Reference model: one word in flight, visible DEC_LAT cycles after accept, held until consumed.
  task automatic test_random();
    int          phase;
    int          left;
    bit          m_ptr, m_id, g, gv;
    logic [31:0] m_word;
    logic [15:0] m_cnt;
    do_reset();
    phase = 0; left = 0; m_ptr = 0; m_id = 0; m_word = 0; m_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      a_v0 = 1'($urandom_range(0, 1));
      a_v1 = 1'($urandom_range(0, 1));
      a_d0 = $urandom; a_d1 = $urandom;
      a_rr = ($urandom_range(0, 3) != 0);
      a_noise = (phase == 1) ? 9'd0 : 9'($urandom);
      gv = (phase == 0) && (a_v0 || a_v1);
      g  = (a_v0 && a_v1) ? m_ptr : a_v1;
      #1;
      checks++;
      if ({a_r0, a_r1} !== {gv && !g, gv && g} || a_rv !== (phase == 2) || a_busy !== (phase != 0)) begin
        errors++; $display("FAIL rand_ctrl[%0d] got rdy=%b%b rv=%b busy=%b exp %b%b %b %b", c, a_r0, a_r1, a_rv, a_busy,
                           gv && !g, gv && g, phase == 2, phase != 0);
      end
      checks++;
      if (a_word !== m_word || a_cnt !== m_cnt) begin
        errors++; $display("FAIL rand_state[%0d] got word=%h cnt=%h exp %h %h", c, a_word, a_cnt, m_word, m_cnt);
      end
      if (phase == 2) begin
        checks++;
        if (a_id !== m_id || a_rc !== m_word[5:0] || a_ri !== m_word[2:0]) begin
          errors++; $display("FAIL rand_resp[%0d] got id=%b comp=%h inst=%h exp %b %h %h", c, a_id, a_rc, a_ri, m_id, m_word[5:0], m_word[2:0]);
        end
      end
      if (phase == 0 && gv) begin
        m_word = g ? a_d1 : a_d0;
        m_id = g; m_ptr = !g; m_cnt = m_cnt + 16'd1;
        phase = 1; left = 1;
      end else if (phase == 1) begin
        left--;
        if (left == 0) phase = 2;
      end else if (phase == 2 && a_rr) begin
        phase = 0;
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid_wait();
    test_sweep();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
